// File: rtl/common_enums.sv
// Shared turn-timer types and time-control tables.
// Mode select maps to base seconds and per-move increment.
package common_enums;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } turn_state_t;

  localparam logic [9:0] BASE_M0 = 10'd60;
  localparam logic [9:0] BASE_M1 = 10'd180;
  localparam logic [9:0] BASE_M2 = 10'd300;
  localparam logic [9:0] BASE_M3 = 10'd600;

  localparam logic [2:0] INC_M0 = 3'd0;
  localparam logic [2:0] INC_M1 = 3'd2;
  localparam logic [2:0] INC_M2 = 3'd3;
  localparam logic [2:0] INC_M3 = 3'd5;

  function automatic logic [9:0] mode_base(
    input logic [1:0] m
  );
    logic [9:0] r;
    unique case (m)
      2'd0: r = BASE_M0;
      2'd1: r = BASE_M1;
      2'd2: r = BASE_M2;
      2'd3: r = BASE_M3;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] mode_inc(
    input logic [1:0] m
  );
    logic [2:0] r;
    unique case (m)
      2'd0: r = INC_M0;
      2'd1: r = INC_M1;
      2'd2: r = INC_M2;
      2'd3: r = INC_M3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts while enabled,
// pulses tick combinationally at terminal count.
module sec_tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW =
    (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] TERM =
    CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == TERM);

  // prescaler: clear wins, holds when disabled
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/turn_timer_ctrl.sv
// Two-player chess clock with increment,
// pause, flag detection and move acknowledge.
module turn_timer_ctrl
  import common_enums::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TIME_W      = 12
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode_sel,
  input  logic              first_player,
  input  logic              moved,
  input  logic              pause,
  output logic              curr_player,
  output logic [TIME_W-1:0] white_secs,
  output logic [TIME_W-1:0] black_secs,
  output logic              running,
  output logic              move_ack,
  output logic              time_up,
  output logic              loser
);

  localparam logic [TIME_W-1:0] TMAX = '1;

  turn_state_t       state;
  logic [TIME_W-1:0] inc_r;
  logic              tick;
  logic              go;
  logic              start_ok;
  logic              flag;
  logic              mv_ok;
  logic              clear;
  logic [TIME_W-1:0] act;
  logic [TIME_W-1:0] dec_v;
  logic [TIME_W:0]   add_w;
  logic [TIME_W-1:0] sum_v;
  logic [TIME_W-1:0] nxt_v;

  assign start_ok = start &&
    (state == ST_IDLE || state == ST_DONE);
  assign go    = (state == ST_RUN) && !pause;
  assign act   = curr_player ? black_secs
                             : white_secs;
  assign dec_v = tick ? act - TIME_W'(1) : act;
  assign flag  = tick && (dec_v == '0);
  assign mv_ok = go && moved && !flag;
  assign add_w = {1'b0, dec_v} + {1'b0, inc_r};
  assign sum_v = add_w[TIME_W] ? TMAX
                               : add_w[TIME_W-1:0];
  assign nxt_v = flag  ? '0    :
                 mv_ok ? sum_v : dec_v;
  assign clear = start_ok || mv_ok;

  assign running = (state == ST_RUN);
  assign time_up = (state == ST_DONE);

  sec_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .enable  (go),
    .clear   (clear),
    .tick    (tick)
  );

  // game state machine
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (start_ok) state <= ST_RUN;
        ST_RUN: begin
          if (pause)     state <= ST_PAUSED;
          else if (flag) state <= ST_DONE;
        end
        ST_PAUSED: if (!pause) state <= ST_RUN;
        ST_DONE: if (start_ok) state <= ST_RUN;
      endcase
    end
  end

  // timers, side to move, ack and loser
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      white_secs  <= '0;
      black_secs  <= '0;
      inc_r       <= '0;
      curr_player <= 1'b0;
      move_ack    <= 1'b0;
      loser       <= 1'b0;
    end else begin
      move_ack <= 1'b0;
      if (start_ok) begin
        white_secs  <= TIME_W'(mode_base(mode_sel));
        black_secs  <= TIME_W'(mode_base(mode_sel));
        inc_r       <= TIME_W'(mode_inc(mode_sel));
        curr_player <= first_player;
        loser       <= 1'b0;
      end else if (go) begin
        if (curr_player) black_secs <= nxt_v;
        else             white_secs <= nxt_v;
        if (flag) loser <= curr_player;
        if (mv_ok) begin
          curr_player <= ~curr_player;
          move_ack    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// Scoreboarded bench for turn_timer_ctrl.
// Small prescale so seconds pass in 10 cycles.
module tb_turn_timer_ctrl;

  localparam int F     = 10;
  localparam int TW    = 10;
  localparam int TMAXV = (1 << TW) - 1;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode_sel = 2'd0;
  logic          first_player = 1'b0;
  logic          moved = 1'b0;
  logic          pause = 1'b0;
  logic          curr_player;
  logic [TW-1:0] white_secs;
  logic [TW-1:0] black_secs;
  logic          running;
  logic          move_ack;
  logic          time_up;
  logic          loser;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cur;
    int w;
    int b;
    int run;
    int ack;
    int tu;
    int los;
  } exp_t;

  exp_t sbq[$];

  int m_st, m_pre, m_w, m_b, m_inc;
  int m_cur, m_ack, m_los;

  turn_timer_ctrl #(
    .CLK_FREQ_HZ(F),
    .TIME_W     (TW)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .mode_sel    (mode_sel),
    .first_player(first_player),
    .moved       (moved),
    .pause       (pause),
    .curr_player (curr_player),
    .white_secs  (white_secs),
    .black_secs  (black_secs),
    .running     (running),
    .move_ack    (move_ack),
    .time_up     (time_up),
    .loser       (loser)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  function automatic int base_of(input int m);
    case (m)
      0: return 60;
      1: return 180;
      2: return 300;
      default: return 600;
    endcase
  endfunction

  function automatic int inc_of(input int m);
    case (m)
      0: return 0;
      1: return 2;
      2: return 3;
      default: return 5;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_pre = 0; m_w = 0; m_b = 0;
    m_inc = 0; m_cur = 0; m_ack = 0; m_los = 0;
    sbq.delete();
  endtask

  task automatic model_step();
    int a;
    int p;
    bit tk;
    m_ack = 0;
    case (m_st)
      0, 3: begin
        if (start) begin
          m_w   = base_of(int'(mode_sel));
          m_b   = m_w;
          m_inc = inc_of(int'(mode_sel));
          m_cur = int'(first_player);
          m_pre = 0;
          m_los = 0;
          m_st  = 1;
        end
      end
      1: begin
        if (pause) begin
          m_st = 2;
        end else begin
          p  = m_cur;
          a  = (p != 0) ? m_b : m_w;
          tk = (m_pre == F - 1);
          if (tk) a = a - 1;
          if (tk && a == 0) begin
            m_st  = 3;
            m_los = p;
            m_pre = 0;
          end else if (moved) begin
            a = a + m_inc;
            if (a > TMAXV) a = TMAXV;
            m_cur = 1 - m_cur;
            m_ack = 1;
            m_pre = 0;
          end else begin
            m_pre = tk ? 0 : m_pre + 1;
          end
          if (p != 0) m_b = a;
          else        m_w = a;
        end
      end
      default: begin
        if (!pause) m_st = 1;
      end
    endcase
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge CLOCK_50);
    model_step();
    e.cur = m_cur;
    e.w   = m_w;
    e.b   = m_b;
    e.run = (m_st == 1) ? 1 : 0;
    e.ack = m_ack;
    e.tu  = (m_st == 3) ? 1 : 0;
    e.los = m_los;
    sbq.push_back(e);
    @(negedge CLOCK_50);
    e = sbq.pop_front();
    chk("sb_cur",   32'(curr_player), e.cur);
    chk("sb_white", 32'(white_secs),  e.w);
    chk("sb_black", 32'(black_secs),  e.b);
    chk("sb_run",   32'(running),     e.run);
    chk("sb_ack",   32'(move_ack),    e.ack);
    chk("sb_tup",   32'(time_up),     e.tu);
    chk("sb_loser", 32'(loser),       e.los);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_start(
    input logic [1:0] m,
    input logic       fp
  );
    mode_sel     = m;
    first_player = fp;
    start        = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic pulse_move();
    moved = 1'b1;
    cycle();
    moved = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_run",   32'(running),     0);
    chk("rst_cur",   32'(curr_player), 0);
    chk("rst_white", 32'(white_secs),  0);
    chk("rst_black", 32'(black_secs),  0);
    chk("rst_ack",   32'(move_ack),    0);
    chk("rst_tup",   32'(time_up),     0);
    chk("rst_loser", 32'(loser),       0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    chk("init_run",   32'(running),    0);
    chk("init_white", 32'(white_secs), 0);
    chk("init_tup",   32'(time_up),    0);
    reset = 1'b0;

    pulse_start(2'd0, 1'b0);
    chk("t1_white", 32'(white_secs),  60);
    chk("t1_black", 32'(black_secs),  60);
    chk("t1_cur",   32'(curr_player), 0);
    chk("t1_run",   32'(running),     1);
    run_n(9);
    chk("t1_white9", 32'(white_secs), 60);
    cycle();
    chk("t1_white10", 32'(white_secs), 59);
    pulse_start(2'd3, 1'b1);
    chk("t1_ign_start_w", 32'(white_secs), 59);
    chk("t1_ign_start_c", 32'(curr_player), 0);

    do_reset();
    pulse_start(2'd1, 1'b0);
    run_n(25);
    chk("t2_w25", 32'(white_secs), 178);
    pulse_move();
    chk("t2_white", 32'(white_secs),  180);
    chk("t2_cur",   32'(curr_player), 1);
    chk("t2_ack",   32'(move_ack),    1);
    cycle();
    chk("t2_ack_off", 32'(move_ack), 0);
    run_n(8);
    chk("t2_black9", 32'(black_secs), 180);
    cycle();
    chk("t2_black10", 32'(black_secs), 179);

    do_reset();
    pulse_start(2'd0, 1'b0);
    run_n(590);
    chk("t3_w1", 32'(white_secs), 1);
    run_n(9);
    pulse_move();
    chk("t3_tup",   32'(time_up),     1);
    chk("t3_loser", 32'(loser),       0);
    chk("t3_ack",   32'(move_ack),    0);
    chk("t3_cur",   32'(curr_player), 0);
    chk("t3_white", 32'(white_secs),  0);
    chk("t3_run",   32'(running),     0);
    pulse_move();
    chk("t3_done_ack", 32'(move_ack), 0);
    pause = 1'b1;
    run_n(3);
    pause = 1'b0;
    chk("t3_done_tup", 32'(time_up), 1);
    pulse_start(2'd2, 1'b1);
    chk("t3_rl_run",   32'(running),     1);
    chk("t3_rl_black", 32'(black_secs),  300);
    chk("t3_rl_white", 32'(white_secs),  300);
    chk("t3_rl_cur",   32'(curr_player), 1);
    chk("t3_rl_tup",   32'(time_up),     0);

    run_n(4);
    pause = 1'b1;
    run_n(20);
    moved = 1'b1;
    cycle();
    moved = 1'b0;
    run_n(16);
    chk("t4_black_p", 32'(black_secs),  300);
    chk("t4_cur_p",   32'(curr_player), 1);
    chk("t4_run_p",   32'(running),     0);
    pause = 1'b0;
    run_n(6);
    chk("t4_black6", 32'(black_secs), 300);
    cycle();
    chk("t4_black7", 32'(black_secs), 299);

    do_reset();
    pulse_start(2'd3, 1'b0);
    for (int i = 0; i < 180; i++) begin
      pulse_move();
      cycle();
    end
    chk("t5_wsat", 32'(white_secs), TMAXV);
    chk("t5_bsat", 32'(black_secs), TMAXV);
    pulse_move();
    chk("t5_wheld", 32'(white_secs), TMAXV);

    do_reset();
    pulse_start(2'd2, 1'b1);
    chk("t6_fresh_b", 32'(black_secs),  300);
    chk("t6_fresh_c", 32'(curr_player), 1);
    chk("sb_drain", 32'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
